seg_scan_ctrl: RTL and testbench
================================

Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the 8-digit seven-segment display. Holds a 32-bit hex value (8 nibbles) with per-digit decimal points and enables, and walks the digits at a programmable rate. For each digit it drives the one-hot digit select and the decoded segment pattern, inserting an anti-ghosting blank window. New values are double-buffered and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

Parameters:
SCAN_DIV, 100000, clock cycles per digit slot (1 kHz per digit at 100 MHz); legal range 2..2^20
BLANK_CYC, 1000, cycles at the start of each slot with all digits off; must be < SCAN_DIV
NUM_DIGITS, 8, digit count; fixed at 8 for this revision

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-high reset
load  in  1  single-cycle strobe; capture value/dp_mask/en_mask/blank_zeros into the pending buffer
value  in  32  nibble i drives digit i (digit 0 = rightmost)
dp_mask  in  8  bit i lights the decimal point of digit i
en_mask  in  8  bit i enables digit i; disabled digits stay dark
blank_zeros  in  1  suppress leading zeros
seg_out  out  8  {a,b,c,d,e,f,g,dp}, active-high, registered
dig_sel  out  8  one-hot digit enable, active-high, registered
frame_done  out  1  one-cycle pulse when the scan wraps from digit 7 to digit 0
pending  out  1  high while a loaded value awaits commit

Behaviour:
- Reset (async assert, sync release) clears prescaler, idx, display and pending registers, seg_out, dig_sel, frame_done and pending, all to 0.
- Prescaler counts 0..SCAN_DIV-1. tick = (count==SCAN_DIV-1). On tick, count goes to 0 and idx increments mod 8.
- wrap = tick && idx==7. frame_done is registered and pulses high on the cycle after wrap.
- On load, the inputs go into the pending buffer and pending goes to 1. A later load before commit overwrites the buffer (latest wins).
- On wrap with pending=1, the display registers take the pending buffer and pending clears.
- If load and wrap occur on the same cycle, the load inputs commit directly to the display registers and pending stays 0.
- Blank window: dig_sel=0 and seg_out=0 while count < BLANK_CYC.
- Outside the blank window:
  - dig_sel = (1<<idx) & en_mask.
  - seg_out = {hex pattern of nibble[idx], dp_mask[idx]}.
  - Both outputs are 0 if en_mask[idx]=0.
  - Both outputs are 0 if the digit is leading-zero suppressed: blank_zeros=1, idx>0, and nibbles idx..7 are all 0. Digit 0 is never suppressed.
- Output registers follow count/idx with 1-cycle latency. The slot length seen at the pins is exactly SCAN_DIV cycles, of which BLANK_CYC are dark.
- Hex patterns, a..g (bit7..bit1):
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
- Reset mid-frame drops any pending load; the display restarts dark with value 0.

Decomposition:
- Package seg_pkg holds:
  - the SEG_* pattern constants and a function hex_to_seg(4b)->7b in {a..g} order;
  - localparams DIG_W=3 and SEG_DP_BIT=0.
- One sub-module, seg_scan_timer: prescaler plus idx counter, producing tick, wrap, idx and in_blank. Everything else lives in seg_scan_ctrl.

Test Plan:
1. Reset release, SCAN_DIV=4, BLANK_CYC=1, load value=0x76543210, en_mask=FF, dp_mask=00 -> first frame shows all digits dark (commit at wrap). The second frame has dig_sel 01,02,..,80, each lit 3 of 4 cycles; the digit-0 slot shows seg_out=0xFC and the digit-1 slot shows 0x60.
2. Load 0x11111111 mid-frame -> pending=1, and dig_sel/seg_out continue the old value until wrap. pending clears on the wrap cycle, and frame_done pulses once per 32 cycles.
3. Two loads (0xAAAAAAAA then 0x0000000F) in the same frame -> only 0x0000000F appears. The digit-0 slot shows seg_out=0x8E.
4. Load asserted on the exact wrap cycle with value=0x000000C0 -> the next slot (digit 0) already shows the new value (seg_out=0xFC) and pending stays 0.
5. value=0x00000105, blank_zeros=1, dp_mask=0x04 -> digits 3..7 have dig_sel=0. Digit 2 shows 0x61 (1 with dp), digit 1 shows 0xFC, digit 0 shows 0xB6.
6. en_mask=0x0F, then assert rst mid-slot -> digits 4..7 are never selected. On rst all outputs go 0 immediately, and after release the display stays dark with pending=0.

Source files
------------

// File: rtl/seg_pkg.sv
// Shared constants and hex-to-segment decode for the seven-segment scan controller.
package seg_pkg;

    localparam int unsigned DIG_W      = 3;
    localparam int unsigned SEG_DP_BIT = 0;

    // Segment patterns in {a,b,c,d,e,f,g} order, active-high.
    localparam logic [6:0] SEG_0 = 7'b1111110;
    localparam logic [6:0] SEG_1 = 7'b0110000;
    localparam logic [6:0] SEG_2 = 7'b1101101;
    localparam logic [6:0] SEG_3 = 7'b1111001;
    localparam logic [6:0] SEG_4 = 7'b0110011;
    localparam logic [6:0] SEG_5 = 7'b1011011;
    localparam logic [6:0] SEG_6 = 7'b1011111;
    localparam logic [6:0] SEG_7 = 7'b1110000;
    localparam logic [6:0] SEG_8 = 7'b1111111;
    localparam logic [6:0] SEG_9 = 7'b1111011;
    localparam logic [6:0] SEG_A = 7'b1110111;
    localparam logic [6:0] SEG_B = 7'b0011111;
    localparam logic [6:0] SEG_C = 7'b1001110;
    localparam logic [6:0] SEG_D = 7'b0111101;
    localparam logic [6:0] SEG_E = 7'b1001111;
    localparam logic [6:0] SEG_F = 7'b1000111;

    // Decode one hex nibble to its a..g pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = SEG_0;
            4'h1:    seg = SEG_1;
            4'h2:    seg = SEG_2;
            4'h3:    seg = SEG_3;
            4'h4:    seg = SEG_4;
            4'h5:    seg = SEG_5;
            4'h6:    seg = SEG_6;
            4'h7:    seg = SEG_7;
            4'h8:    seg = SEG_8;
            4'h9:    seg = SEG_9;
            4'hA:    seg = SEG_A;
            4'hB:    seg = SEG_B;
            4'hC:    seg = SEG_C;
            4'hD:    seg = SEG_D;
            4'hE:    seg = SEG_E;
            default: seg = SEG_F;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg_scan_timer.sv
// Slot prescaler and digit index counter for the display scan.
module seg_scan_timer
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLANK_CYC = 1000
) (
    input  logic             clk,
    input  logic             rst,
    output logic             tick_o,
    output logic             wrap_o,
    output logic [DIG_W-1:0] idx_o,
    output logic             in_blank_o
);

    localparam int unsigned      CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] IDX_LAST = '1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [DIG_W-1:0] idx_q, idx_d;

    assign tick_o = (count_q == CNT_LAST);
    assign wrap_o = tick_o && (idx_q == IDX_LAST);
    assign idx_o  = idx_q;

    // Dark window at the head of every slot; a zero-length window never blanks.
    generate
        if (BLANK_CYC == 0) begin : g_no_blank
            assign in_blank_o = 1'b0;
        end else begin : g_blank
            assign in_blank_o = (count_q < CNT_W'(BLANK_CYC));
        end
    endgenerate

    // Next count/index: count rolls over on tick, index advances mod 8.
    always_comb begin
        count_d = count_q + CNT_W'(1);
        idx_d   = idx_q;
        if (tick_o) begin
            count_d = '0;
            idx_d   = idx_q + DIG_W'(1);
        end
    end

    // Counter state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q <= '0;
            idx_q   <= '0;
        end else begin
            count_q <= count_d;
            idx_q   <= idx_d;
        end
    end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Eight-digit seven-segment scan controller with frame-aligned double buffering.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 100000,
    parameter int unsigned BLANK_CYC  = 1000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [4*NUM_DIGITS-1:0]   value,
    input  logic [NUM_DIGITS-1:0]     dp_mask,
    input  logic [NUM_DIGITS-1:0]     en_mask,
    input  logic                      blank_zeros,
    output logic [7:0]                seg_out,
    output logic [NUM_DIGITS-1:0]     dig_sel,
    output logic                      frame_done,
    output logic                      pending
);

    localparam int unsigned VAL_W = 4 * NUM_DIGITS;

    logic             tick, wrap, in_blank;
    logic [DIG_W-1:0] idx;

    logic [VAL_W-1:0]      pend_val_q, pend_val_d, disp_val_q, disp_val_d;
    logic [NUM_DIGITS-1:0] pend_dp_q, pend_dp_d, disp_dp_q, disp_dp_d;
    logic [NUM_DIGITS-1:0] pend_en_q, pend_en_d, disp_en_q, disp_en_d;
    logic                  pend_bz_q, pend_bz_d, disp_bz_q, disp_bz_d;
    logic                  pending_q, pending_d;

    logic [7:0]            seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  frame_done_q;

    logic [3:0] cur_nib;
    logic       upper_zero, suppress, lit;

    seg_scan_timer #(
        .SCAN_DIV  (SCAN_DIV),
        .BLANK_CYC (BLANK_CYC)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .tick_o     (tick),
        .wrap_o     (wrap),
        .idx_o      (idx),
        .in_blank_o (in_blank)
    );

    // Frame wrap is by construction the last tick of digit 7.
    assert property (@(posedge clk) disable iff (rst) wrap |-> tick);

    // Double buffer: loads park in the pending buffer and commit on wrap;
    // a load coinciding with wrap bypasses the buffer.
    always_comb begin
        pend_val_d = pend_val_q;
        pend_dp_d  = pend_dp_q;
        pend_en_d  = pend_en_q;
        pend_bz_d  = pend_bz_q;
        disp_val_d = disp_val_q;
        disp_dp_d  = disp_dp_q;
        disp_en_d  = disp_en_q;
        disp_bz_d  = disp_bz_q;
        pending_d  = pending_q;
        if (load && wrap) begin
            disp_val_d = value;
            disp_dp_d  = dp_mask;
            disp_en_d  = en_mask;
            disp_bz_d  = blank_zeros;
            pending_d  = 1'b0;
        end else if (load) begin
            pend_val_d = value;
            pend_dp_d  = dp_mask;
            pend_en_d  = en_mask;
            pend_bz_d  = blank_zeros;
            pending_d  = 1'b1;
        end else if (wrap && pending_q) begin
            disp_val_d = pend_val_q;
            disp_dp_d  = pend_dp_q;
            disp_en_d  = pend_en_q;
            disp_bz_d  = pend_bz_q;
            pending_d  = 1'b0;
        end
    end

    // Pixel decode for the current slot: blanking, enable and leading-zero suppression.
    always_comb begin
        cur_nib    = disp_val_q[{idx, 2'b00} +: 4];
        upper_zero = ((disp_val_q >> {idx, 2'b00}) == '0);
        suppress   = disp_bz_q && (idx != '0) && upper_zero;
        lit        = !in_blank && disp_en_q[idx] && !suppress;
        dig_sel_d  = '0;
        seg_out_d  = '0;
        if (lit) begin
            dig_sel_d = NUM_DIGITS'(1) << idx;
            seg_out_d = {hex_to_seg(cur_nib), disp_dp_q[idx]};
        end
    end

    // Buffer, display and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend_val_q   <= '0;
            pend_dp_q    <= '0;
            pend_en_q    <= '0;
            pend_bz_q    <= 1'b0;
            disp_val_q   <= '0;
            disp_dp_q    <= '0;
            disp_en_q    <= '0;
            disp_bz_q    <= 1'b0;
            pending_q    <= 1'b0;
            seg_out_q    <= '0;
            dig_sel_q    <= '0;
            frame_done_q <= 1'b0;
        end else begin
            pend_val_q   <= pend_val_d;
            pend_dp_q    <= pend_dp_d;
            pend_en_q    <= pend_en_d;
            pend_bz_q    <= pend_bz_d;
            disp_val_q   <= disp_val_d;
            disp_dp_q    <= disp_dp_d;
            disp_en_q    <= disp_en_d;
            disp_bz_q    <= disp_bz_d;
            pending_q    <= pending_d;
            seg_out_q    <= seg_out_d;
            dig_sel_q    <= dig_sel_d;
            frame_done_q <= wrap;
        end
    end

    assign seg_out    = seg_out_q;
    assign dig_sel    = dig_sel_q;
    assign frame_done = frame_done_q;
    assign pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl with a cycle-number based reference model.
module tb_seg_scan_ctrl;

    localparam int unsigned SCAN_DIV  = 4;
    localparam int unsigned BLANK_CYC = 1;
    localparam int unsigned FRAME     = SCAN_DIV * 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load = 1'b0;
    logic [31:0] value = '0;
    logic [7:0]  dp_mask = '0;
    logic [7:0]  en_mask = '0;
    logic        blank_zeros = 1'b0;
    logic [7:0]  seg_out, dig_sel;
    logic        frame_done, pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(
        .SCAN_DIV   (SCAN_DIV),
        .BLANK_CYC  (BLANK_CYC),
        .NUM_DIGITS (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .load        (load),
        .value       (value),
        .dp_mask     (dp_mask),
        .en_mask     (en_mask),
        .blank_zeros (blank_zeros),
        .seg_out     (seg_out),
        .dig_sel     (dig_sel),
        .frame_done  (frame_done),
        .pending     (pending)
    );

    // Reference model: position derives from the number of clock edges since reset.
    logic [6:0]  hex_tab [16] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
                                  7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
                                  7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
                                  7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};
    int unsigned cyc;
    logic [31:0] m_val, b_val;
    logic [7:0]  m_dp, m_en, b_dp, b_en;
    logic        m_bz, b_bz, m_pend;
    logic [7:0]  e_seg, e_dig;
    logic        e_fd;

    task automatic model_clear();
        cyc = 0;
        m_val = '0; m_dp = '0; m_en = '0; m_bz = 1'b0;
        b_val = '0; b_dp = '0; b_en = '0; b_bz = 1'b0;
        m_pend = 1'b0; e_seg = '0; e_dig = '0; e_fd = 1'b0;
    endtask

    // Advance one clock, updating the model with the inputs seen at that edge.
    task automatic clk_step();
        int unsigned pos, digit;
        logic [31:0] upper;
        logic        lit;
        @(posedge clk);
        pos   = cyc % SCAN_DIV;
        digit = (cyc / SCAN_DIV) % 8;
        upper = m_val >> (4 * digit);
        lit   = (pos >= BLANK_CYC) && m_en[digit] && !(m_bz && digit != 0 && upper == 0);
        e_dig = lit ? 8'(1 << digit) : 8'h00;
        e_seg = lit ? {hex_tab[m_val[4*digit +: 4]], m_dp[digit]} : 8'h00;
        e_fd  = ((cyc % FRAME) == FRAME - 1);
        if (load && e_fd) begin
            m_val = value; m_dp = dp_mask; m_en = en_mask; m_bz = blank_zeros; m_pend = 1'b0;
        end else if (load) begin
            b_val = value; b_dp = dp_mask; b_en = en_mask; b_bz = blank_zeros; m_pend = 1'b1;
        end else if (e_fd && m_pend) begin
            m_val = b_val; m_dp = b_dp; m_en = b_en; m_bz = b_bz; m_pend = 1'b0;
        end
        cyc++;
        #1;
    endtask

    task automatic set_inputs(input logic [31:0] v, input logic [7:0] dp,
                              input logic [7:0] en, input logic bz);
        value = v; dp_mask = dp; en_mask = en; blank_zeros = bz;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        n_tests++;
        if ({seg_out, dig_sel, frame_done, pending} !== 18'h0) begin
            n_fail++;
            $display("FAIL reset_state got seg=%h dig=%h fd=%b pend=%b want all 0",
                     seg_out, dig_sel, frame_done, pending);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_first_frame();
        int unsigned p;
        int lit_f1 = 0;
        int lit_f2 = 0;
        set_inputs(32'h7654_3210, 8'h00, 8'hFF, 1'b0);
        load = 1'b1;
        clk_step();
        load = 1'b0;
        for (int i = 0; i < 63; i++) begin
            clk_step();
            p = cyc - 1;
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL first_frame p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         p, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
            if (dig_sel != 8'h00) begin
                if (p < FRAME) lit_f1++; else lit_f2++;
            end
            if (p == 34 || p == 38 || p == 62) begin
                n_tests++;
                if ((p == 34 && {seg_out, dig_sel} !== 16'hFC01) ||
                    (p == 38 && {seg_out, dig_sel} !== 16'h6002) ||
                    (p == 62 && dig_sel !== 8'h80)) begin
                    n_fail++;
                    $display("FAIL first_frame_slot p=%0d got seg=%h dig=%h", p, seg_out, dig_sel);
                end
            end
        end
        n_tests++;
        if (lit_f1 != 0) begin
            n_fail++;
            $display("FAIL first_frame_dark got %0d lit cycles want 0", lit_f1);
        end
        n_tests++;
        if (lit_f2 != 24) begin
            n_fail++;
            $display("FAIL second_frame_lit got %0d lit cycles want 24", lit_f2);
        end
    endtask

    task automatic test_pending_update();
        int unsigned p;
        int fd_cnt = 0;
        repeat (5) clk_step();
        set_inputs(32'h1111_1111, 8'h00, 8'hFF, 1'b0);
        load = 1'b1;
        clk_step();
        load = 1'b0;
        n_tests++;
        if (pending !== 1'b1) begin
            n_fail++;
            $display("FAIL pending_set got %b want 1", pending);
        end
        for (int i = 0; i < 64; i++) begin
            clk_step();
            p = cyc - 1;
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL pending_update p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         p, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
            if (frame_done) fd_cnt++;
            if (p == 74 || p == 98) begin
                n_tests++;
                if ((p == 74 && seg_out !== 8'hDA) || (p == 98 && seg_out !== 8'h60)) begin
                    n_fail++;
                    $display("FAIL pending_old_new p=%0d got seg=%h", p, seg_out);
                end
            end
        end
        n_tests++;
        if (fd_cnt != 2) begin
            n_fail++;
            $display("FAIL frame_done_rate got %0d pulses want 2", fd_cnt);
        end
    endtask

    task automatic test_latest_wins();
        int unsigned p, commit_p;
        while (cyc % FRAME != 2) clk_step();
        set_inputs(32'hAAAA_AAAA, 8'h00, 8'hFF, 1'b0);
        load = 1'b1; clk_step(); load = 1'b0;
        repeat (3) clk_step();
        set_inputs(32'h0000_000F, 8'h00, 8'hFF, 1'b0);
        load = 1'b1; clk_step(); load = 1'b0;
        commit_p = (cyc / FRAME + 1) * FRAME;
        for (int i = 0; i < 64; i++) begin
            clk_step();
            p = cyc - 1;
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL latest_wins p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         p, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
            if (p == commit_p + 2 || p == commit_p + 6) begin
                n_tests++;
                if ((p == commit_p + 2 && seg_out !== 8'h8E) || (p == commit_p + 6 && seg_out !== 8'hFC)) begin
                    n_fail++;
                    $display("FAIL latest_wins_slot p=%0d got seg=%h", p, seg_out);
                end
            end
        end
    endtask

    task automatic test_load_on_wrap();
        while (cyc % FRAME != FRAME - 1) clk_step();
        set_inputs(32'h0000_00C0, 8'h00, 8'hFF, 1'b0);
        load = 1'b1; clk_step(); load = 1'b0;
        n_tests++;
        if ({frame_done, pending} !== 2'b10) begin
            n_fail++;
            $display("FAIL wrap_load_pending got fd=%b pend=%b want fd=1 pend=0", frame_done, pending);
        end
        for (int i = 0; i < 2; i++) begin
            clk_step();
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL wrap_load p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         cyc - 1, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
        end
        n_tests++;
        if ({seg_out, dig_sel} !== 16'hFC01) begin
            n_fail++;
            $display("FAIL wrap_load_digit0 got seg=%h dig=%h want seg=fc dig=01", seg_out, dig_sel);
        end
    endtask

    task automatic test_leading_zero();
        int unsigned p, commit_p, d;
        logic [15:0] want [8] = '{16'hB601, 16'hFC02, 16'h6104, 16'h0000,
                                  16'h0000, 16'h0000, 16'h0000, 16'h0000};
        set_inputs(32'h0000_0105, 8'h04, 8'hFF, 1'b1);
        load = 1'b1; clk_step(); load = 1'b0;
        commit_p = (cyc / FRAME + 1) * FRAME;
        for (int i = 0; i < 96; i++) begin
            clk_step();
            p = cyc - 1;
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL leading_zero p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         p, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
            if (p >= commit_p && p < commit_p + FRAME && p % SCAN_DIV == 2) begin
                d = (p - commit_p) / SCAN_DIV;
                n_tests++;
                if ({seg_out, dig_sel} !== want[d]) begin
                    n_fail++;
                    $display("FAIL leading_zero_digit%0d got seg=%h dig=%h want %h", d, seg_out, dig_sel, want[d]);
                end
            end
        end
    endtask

    task automatic test_enable_and_reset();
        logic [7:0] dig_or = '0;
        set_inputs($urandom, 8'($urandom), 8'h0F, 1'b0);
        load = 1'b1; clk_step(); load = 1'b0;
        for (int i = 0; i < 96; i++) begin
            clk_step();
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL enable_mask p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         cyc - 1, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
            if (i >= 64) dig_or = dig_or | dig_sel;
        end
        n_tests++;
        if (dig_or !== 8'h0F) begin
            n_fail++;
            $display("FAIL enable_mask_digits got %h want 0f", dig_or);
        end
        while (!(((cyc - 1) % SCAN_DIV == 2) && (((cyc - 1) / SCAN_DIV) % 8 < 4))) clk_step();
        set_inputs(32'hFFFF_FFFF, 8'hFF, 8'hFF, 1'b0);
        load = 1'b1; clk_step(); load = 1'b0;
        n_tests++;
        if (pending !== 1'b1 || dig_sel === 8'h00) begin
            n_fail++;
            $display("FAIL pre_reset got pend=%b dig=%h want pend=1 dig nonzero", pending, dig_sel);
        end
        #2 rst = 1'b1;
        #1;
        n_tests++;
        if ({seg_out, dig_sel, frame_done, pending} !== 18'h0) begin
            n_fail++;
            $display("FAIL async_reset got seg=%h dig=%h fd=%b pend=%b want all 0",
                     seg_out, dig_sel, frame_done, pending);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_clear();
        dig_or = '0;
        for (int i = 0; i < 64; i++) begin
            clk_step();
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL after_reset p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         cyc - 1, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
            dig_or = dig_or | dig_sel | {7'b0, pending};
        end
        n_tests++;
        if (dig_or !== 8'h00) begin
            n_fail++;
            $display("FAIL after_reset_dark got %h want 00", dig_or);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            load = ($urandom_range(0, 7) == 0) ||
                   ((cyc % FRAME == FRAME - 1) && ($urandom_range(0, 1) == 1));
            set_inputs($urandom & ($urandom_range(0, 1) == 1 ? 32'h0000_0FFF : 32'hFFFF_FFFF),
                       8'($urandom), 8'($urandom), 1'($urandom));
            clk_step();
            load = 1'b0;
            n_tests++;
            if ({seg_out, dig_sel, frame_done, pending} !== {e_seg, e_dig, e_fd, m_pend}) begin
                n_fail++;
                $display("FAIL random p=%0d got seg=%h dig=%h fd=%b pend=%b want seg=%h dig=%h fd=%b pend=%b",
                         cyc - 1, seg_out, dig_sel, frame_done, pending, e_seg, e_dig, e_fd, m_pend);
            end
        end
    endtask

    initial begin
        model_clear();
        test_reset();
        test_first_frame();
        test_pending_update();
        test_latest_wins();
        test_load_on_wrap();
        test_leading_zero();
        test_enable_and_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
